// File: rtl/ram_n.sv
// ram_n: WIDTH x 2^ADDR_W word memory.
// Port A is write/read and port B is read-only. Both reads are registered.
// An optional clear sequencer zeroes every word after reset and then raises ready.
module ram_n #(
  parameter int WIDTH          = 16,
  parameter int ADDR_W         = 3,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  output logic [WIDTH-1:0]  out,
  input  logic [ADDR_W-1:0] address_b,
  output logic [WIDTH-1:0]  out_b,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Without the clear sequencer, the memory is usable straight out of reset.
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
  localparam logic   RST_READY = (CLEAR_ON_RESET == 0);

  state_t             state;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [WIDTH-1:0]   mem [DEPTH];

  // The write port is shared: the sequencer owns it in CLEAR, and port A owns it in READY.
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic               last_clr;

  assign last_clr = (clr_cnt == ADDR_W'(DEPTH - 1));

  // Select the write source. Port A traffic is ignored while clearing.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = in;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_data = '0;
    end else if (load) begin
      wr_en   = 1'b1;
    end
  end

  // Clear sequencer. After the clear, the state never returns to CLEAR without a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
      ready   <= RST_READY;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (last_clr) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          ready <= 1'b1;
        end
        default: begin
          state <= RST_STATE;
        end
      endcase
    end
  end

  // Memory array. It has no reset of its own, and no writes happen while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Port A read. On a write, the new data is returned in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else if (state == CLEAR) begin
      out <= '0;
    end else begin
      out <= load ? in : mem[address];
    end
  end

  // Port B read. If port A writes the same word on this edge, port B returns the new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_b <= '0;
    end else if (state == CLEAR) begin
      out_b <= '0;
    end else begin
      out_b <= (load && (address_b == address)) ? in : mem[address_b];
    end
  end

endmodule

// File: tb/tb_ram_n.sv
// Directed testbench for ram_n with WIDTH=16 and ADDR_W=3.
// dut uses the clear sequencer; dut0 is built without it.
module tb_ram_n;

  logic        clk = 1'b0;
  logic        reset, load;
  logic [2:0]  address, address_b;
  logic [15:0] in, out, out_b;
  logic        ready;

  logic        reset0, load0;
  logic [2:0]  address0, address_b0;
  logic [15:0] in0, out0, out_b0;
  logic        ready0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_n #(.WIDTH(16), .ADDR_W(3), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .load(load), .address(address), .in(in),
    .out(out), .address_b(address_b), .out_b(out_b), .ready(ready)
  );

  ram_n #(.WIDTH(16), .ADDR_W(3), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .reset(reset0), .load(load0), .address(address0), .in(in0),
    .out(out0), .address_b(address_b0), .out_b(out_b0), .ready(ready0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run a full clear, checking that ready stays low for 7 edges and rises on the 8th.
  task automatic clear_run(input string tag);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("%s_ready_e%0d", tag, e), {31'd0, ready}, (e == 8) ? 32'd1 : 32'd0);
      if (e < 8) check($sformatf("%s_out_e%0d", tag, e), {16'd0, out}, 32'd0);
    end
  endtask

  // Read every word on both ports with opposite address orders, and expect zero.
  task automatic read_zero(input string tag);
    load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address   = 3'(a);
      address_b = 3'(7 - a);
      tick();
      check($sformatf("%s_a%0d", tag, a), {16'd0, out}, 32'd0);
      check($sformatf("%s_b%0d", tag, 7 - a), {16'd0, out_b}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; address = '0; address_b = '0; in = '0;
    reset0 = 1'b1; load0 = 1'b0; address0 = '0; address_b0 = '0; in0 = '0;
    tick();
    tick();
    check("rst_out",    {16'd0, out},   32'd0);
    check("rst_out_b",  {16'd0, out_b}, 32'd0);
    check("rst_ready",  {31'd0, ready}, 32'd0);
    check("rst0_ready", {31'd0, ready0}, 32'd1);
    check("rst0_out",   {16'd0, out0},  32'd0);

    // Writes attempted during the clear must be ignored.
    reset = 1'b0; load = 1'b1; in = 16'hFFFF; address = 3'd3; address_b = 3'd0;
    clear_run("clr1");
    read_zero("clr1_rd");

    // Basic write, then read back on both ports.
    load = 1'b1; address = 3'd5; in = 16'h1234;
    tick();
    check("wr5_out_wf", {16'd0, out}, 32'h1234);
    load = 1'b0; address = 3'd5; address_b = 3'd5;
    tick();
    check("rd5_out",   {16'd0, out},   32'h1234);
    check("rd5_out_b", {16'd0, out_b}, 32'h1234);

    // Same-edge collision: port B sees the new data being written.
    load = 1'b1; address = 3'd2; in = 16'h00AA; address_b = 3'd5;
    tick();
    load = 1'b1; address = 3'd2; in = 16'h5555; address_b = 3'd2;
    tick();
    check("col_out",   {16'd0, out},   32'h5555);
    check("col_out_b", {16'd0, out_b}, 32'h5555);
    load = 1'b0;
    tick();
    check("col_rd_out",   {16'd0, out},   32'h5555);
    check("col_rd_out_b", {16'd0, out_b}, 32'h5555);

    // Ports are independent: fill memory, then sweep both ports in opposite orders.
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; address = 3'(i); in = 16'h0100 + 16'(i);
      tick();
    end
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i); address_b = 3'(7 - i);
      tick();
      check($sformatf("sweep_a%0d", i), {16'd0, out}, 32'h0100 + i);
      check($sformatf("sweep_b%0d", 7 - i), {16'd0, out_b}, 32'h0100 + (7 - i));
    end

    // Reset in READY clears the outputs asynchronously.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_out",   {16'd0, out},   32'd0);
    check("async_out_b", {16'd0, out_b}, 32'd0);
    check("async_ready", {31'd0, ready}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("mid_ready_e3", {31'd0, ready}, 32'd0);
    // Reset again at the 4th clear edge; the clear restarts from the beginning.
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("mid_ready_rst", {31'd0, ready}, 32'd0);
    check("mid_out_rst",   {16'd0, out},   32'd0);
    tick();
    reset = 1'b0;
    clear_run("clr2");
    read_zero("clr2_rd");

    // Without the clear sequencer, dut0 is ready immediately and accepts a write on the first edge.
    reset0 = 1'b0; load0 = 1'b1; address0 = 3'd7; in0 = 16'hBEEF; address_b0 = 3'd0;
    tick();
    check("nc_ready", {31'd0, ready0}, 32'd1);
    load0 = 1'b0; address0 = 3'd7; address_b0 = 3'd7;
    tick();
    check("nc_out",   {16'd0, out0},   32'hBEEF);
    check("nc_out_b", {16'd0, out_b0}, 32'hBEEF);
    check("nc_ready2", {31'd0, ready0}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
